branch_resolve: RTL and testbench
=================================

// Module: branch_resolve
//
// PURPOSE
// - EX-stage consumer of branch_comp results; drives its BrUn input and reads BrEq/BrLT.
// - Decodes branch funct3 into taken/not-taken and checks the outcome against the fetch prediction.
// - On a mispredict, issues a registered PC redirect and a timed pipeline flush.
// - Owns the 2-bit bimodal history table (BHT) used at fetch.
//
// PARAMETERS
// - BHT_ENTRIES   16  number of 2-bit counters; power of 2, >= 2
// - FLUSH_CYCLES  2   cycles flush_o is held after a mispredict; >= 1
// - CNT_W         16  width of statistics counters
//
// PORTS
// - clk_i              in   1      clock, rising edge
// - rst_n_i            in   1      reset, asynchronous, active-low
// - stall_i            in   1      pipeline stall; freezes this block
// - ex_valid_i         in   1      EX slot holds a live instruction
// - ex_is_branch_i     in   1      EX instruction is a conditional branch (B-type)
// - ex_funct3_i        in   3      branch funct3
// - ex_pc_i            in   32     PC of EX instruction
// - ex_target_i        in   32     computed branch target
// - ex_pred_taken_i    in   1      prediction made at fetch, carried down the pipe
// - BrEq_i             in   1      from branch_comp
// - BrLT_i             in   1      from branch_comp
// - BrUn_o             out  1      to branch_comp: 1 = SIGNED compare, 0 = unsigned
// - if_pc_i            in   32     fetch PC, BHT lookup address
// - if_pred_taken_o    out  1      BHT prediction for if_pc_i (combinational)
// - redirect_o         out  1      one-cycle pulse: load redirect_pc_o into PC
// - redirect_pc_o      out  32     corrected PC
// - flush_o            out  1      squash IF/ID/EX contents
// - branch_cnt_o       out  CNT_W  resolved branches
// - mispred_cnt_o      out  CNT_W  mispredicted branches
//
// BEHAVIOUR
// - eval = ex_valid_i & ex_is_branch_i & ~stall_i & (state==IDLE).
// - BrUn_o = funct3[2] & ~funct3[1] (1 for BLT/BGE only); 0 for all other funct3 values and when not a branch. Combinational, same cycle.
// - taken: 000 BEQ=BrEq; 001 BNE=~BrEq; 100/110 BLT(U)=BrLT; 101/111 BGE(U)=~BrLT.
// - funct3 010/011 is illegal: not taken, no BHT update, no counter update, no redirect.
// - mispredict = eval & legal & (taken != ex_pred_taken_i).
// - FSM states IDLE and FLUSH.
//   - IDLE -> FLUSH on mispredict: at the next edge redirect_o=1 for exactly 1 cycle, flush_o=1, cnt=FLUSH_CYCLES-1.
//   - FLUSH: flush_o=1; cnt decrements each unstalled cycle; returns to IDLE when cnt==0.
//   - ex_valid_i is ignored while in FLUSH.
// - redirect_pc_o is registered with redirect_o: taken ? ex_target_i : ex_pc_i+4 (mod 2^32, wraps at 0xFFFFFFFC). Holds its value otherwise.
// - BHT index = pc[$clog2(BHT_ENTRIES)+1:2].
//   - On eval & legal: saturating +1 if taken, -1 if not (00..11). Update lands at the clock edge.
//   - Prediction = counter[1].
//   - Lookup and update at the same index in the same cycle: lookup returns the pre-update value (no bypass).
// - Counters: branch_cnt +1 on eval & legal; mispred_cnt +1 on mispredict; both wrap at 2^CNT_W.
// - stall_i=1: no eval, FSM/cnt/BHT/counters hold; redirect_o is forced 0 and the pulse is deferred to the first unstalled cycle; flush_o holds.
// - Reset (async, any time, including mid-FLUSH):
//   - state=IDLE; redirect_o=0; flush_o=0; redirect_pc_o=0; counters=0.
//   - all BHT entries=01 (weakly not-taken); if_pred_taken_o=0.
//
// STRUCTURE
// - riscv_pkg: FUNCT3_BEQ/BNE/BLT/BGE/BLTU/BGEU constants; bht_cnt_t (logic[1:0]); br_state_e {IDLE, FLUSH}.
// - Sub-module bimodal_bht: counter array, combinational read port, saturating write port, async reset.
// - branch_comp instantiated beside this block at the EX level, not inside it.
//
// TESTING
// - BLT, A=0xFFFFFFFF, B=1, pred=0: BrUn_o=1, BrLT=1 -> taken, redirect 1 cycle later to target, flush 2 cycles, mispred_cnt=1.
// - BLTU, same operands, pred=0: BrUn_o=0, BrLT=0 -> not taken, no redirect, branch_cnt=1, BHT entry 01->00.
// - BEQ at pc=0xFFFFFFFC, not taken, pred=1 -> redirect_pc_o=0x00000000, counter 10->01.
// - Taken branch repeated 4x at pc=0x40: if_pred_taken_o for 0x40 flips 0->1 after the 1st update; counter saturates at 11.
// - Mispredict, then stall_i=1 for 3 cycles -> redirect_o deferred, flush_o held; rst_n_i low mid-FLUSH -> all outputs 0 immediately.
// - funct3=010 with ex_valid_i=1 -> BrUn_o=0, no redirect, counters and BHT unchanged.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the EX-stage branch resolver.
// - FUNCT3_* : B-type funct3 encodings
// - bht_cnt_t : 2-bit bimodal saturating counter
// - br_state_e: resolver FSM states
// - funct3_legal / bht_next: decode and counter-update helpers
package branch_resolve_pkg;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    localparam logic [1:0] BHT_RESET_VAL = 2'b01;

    typedef logic [1:0] bht_cnt_t;

    typedef enum logic {
        IDLE,
        FLUSH
    } br_state_e;

    // 010 and 011 are not branch encodings.
    function automatic logic funct3_legal(input logic [2:0] f3);
        return f3[2:1] != 2'b01;
    endfunction

    function automatic bht_cnt_t bht_next(input bht_cnt_t cur, input logic taken);
        bht_cnt_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != 2'b11) nxt = cur + 2'b01;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// EX-stage branch bus between the pipeline (master) and branch_resolve (slave).
// - ex_*            : live EX instruction fields and fetch prediction
// - BrEq_i/BrLT_i   : results from branch_comp
// - BrUn_o          : compare mode back to branch_comp (1 = signed)
// - redirect_o/redirect_pc_o/flush_o : mispredict recovery towards fetch
interface branch_resolve_if;

    logic        ex_valid_i;
    logic        ex_is_branch_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_target_i;
    logic        ex_pred_taken_i;
    logic        BrEq_i;
    logic        BrLT_i;
    logic        BrUn_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;

    modport master (
        output ex_valid_i, ex_is_branch_i, ex_funct3_i, ex_pc_i, ex_target_i,
               ex_pred_taken_i, BrEq_i, BrLT_i,
        input  BrUn_o, redirect_o, redirect_pc_o, flush_o
    );

    modport slave (
        input  ex_valid_i, ex_is_branch_i, ex_funct3_i, ex_pc_i, ex_target_i,
               ex_pred_taken_i, BrEq_i, BrLT_i,
        output BrUn_o, redirect_o, redirect_pc_o, flush_o
    );

endinterface

// File: rtl/branch_resolve_bht.sv
// Bimodal branch history table: ENTRIES 2-bit saturating counters.
// - clk, rst_n : clock, async active-low reset (all entries -> weakly not-taken)
// - rd_idx     : lookup index; rd_taken = counter MSB, combinational, no write bypass
// - wr_en, wr_idx, wr_taken : saturating increment (taken) / decrement at the edge
module bimodal_bht
    import branch_resolve_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDXW    = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IDXW-1:0] rd_idx,
    output logic            rd_taken,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic            wr_taken
);

    bht_cnt_t cnt_q [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= BHT_RESET_VAL;
            end
        end else if (wr_en) begin
            cnt_q[wr_idx] <= bht_next(cnt_q[wr_idx], wr_taken);
        end
    end

    assign rd_taken = cnt_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolver.
// - clk_i, rst_n_i : clock, async active-low reset
// - stall_i        : freezes FSM, BHT, counters; masks redirect_o until released
// - ex             : EX branch bus (slave side), see branch_resolve_if
// - if_pc_i        : fetch PC used for BHT lookup; if_pred_taken_o is its prediction
// - branch_cnt_o   : resolved legal branches; mispred_cnt_o: mispredicted ones
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             stall_i,
    branch_resolve_if.slave  ex,
    input  logic [31:0]      if_pc_i,
    output logic             if_pred_taken_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int IDXW = $clog2(BHT_ENTRIES);
    localparam int FCW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);

    br_state_e   state;
    logic [FCW-1:0] flush_cnt;
    logic        redirect_q;
    logic [31:0] redirect_pc_q;
    logic        flush_q;

    logic [2:0]  f3;
    logic        taken;
    logic        legal;
    logic        eval;
    logic        resolve;
    logic        mispredict;

    // Only the index bits of the fetch PC reach the BHT.
    logic        unused_if_pc;
    assign unused_if_pc = ^{if_pc_i[31:IDXW+2], if_pc_i[1:0]};

    assign f3 = ex.ex_funct3_i;

    always_comb begin
        taken = 1'b0;
        case (f3)
            FUNCT3_BEQ:               taken = ex.BrEq_i;
            FUNCT3_BNE:               taken = ~ex.BrEq_i;
            FUNCT3_BLT, FUNCT3_BLTU:  taken = ex.BrLT_i;
            FUNCT3_BGE, FUNCT3_BGEU:  taken = ~ex.BrLT_i;
            default:                  taken = 1'b0;
        endcase
    end

    assign legal      = funct3_legal(f3);
    assign eval       = ex.ex_valid_i & ex.ex_is_branch_i & ~stall_i & (state == IDLE);
    assign resolve    = eval & legal;
    assign mispredict = resolve & (taken != ex.ex_pred_taken_i);

    // branch_comp treats BrUn=1 as a signed compare: only BLT/BGE need it.
    assign ex.BrUn_o = ex.ex_is_branch_i & f3[2] & ~f3[1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            flush_cnt     <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
        end else if (!stall_i) begin
            redirect_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        state         <= FLUSH;
                        flush_cnt     <= FLUSH_INIT;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= taken ? ex.ex_target_i : ex.ex_pc_i + 32'd4;
                        flush_q       <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state   <= IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - FCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The pulse stays latched through a stall and shows on the first free cycle.
    assign ex.redirect_o    = redirect_q & ~stall_i;
    assign ex.redirect_pc_o = redirect_pc_q;
    assign ex.flush_o       = flush_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
        end else begin
            if (resolve)    branch_cnt_o  <= branch_cnt_o + CNT_W'(1);
            if (mispredict) mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
        end
    end

    bimodal_bht #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .rd_idx   (if_pc_i[IDXW+1:2]),
        .rd_taken (if_pred_taken_o),
        .wr_en    (resolve),
        .wr_idx   (ex.ex_pc_i[IDXW+1:2]),
        .wr_taken (taken)
    );

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve; branch_comp is modelled inline from BrUn_o.
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] if_pc;
    logic        if_pred;
    logic [15:0] bcnt;
    logic [15:0] mcnt;
    logic [31:0] op_a;
    logic [31:0] op_b;

    int checks   = 0;
    int failures = 0;
    int exp_br   = 0;
    int exp_mp   = 0;

    always #5 clk = ~clk;

    branch_resolve_if bus ();

    // branch_comp: BrUn=1 selects the signed compare.
    assign bus.BrEq_i = (op_a == op_b);
    assign bus.BrLT_i = bus.BrUn_o ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);

    branch_resolve #(
        .BHT_ENTRIES  (16),
        .FLUSH_CYCLES (2),
        .CNT_W        (16)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .stall_i         (stall),
        .ex              (bus),
        .if_pc_i         (if_pc),
        .if_pred_taken_o (if_pred),
        .branch_cnt_o    (bcnt),
        .mispred_cnt_o   (mcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] a, input logic [31:0] b, input logic pred);
        bus.ex_valid_i      = 1'b1;
        bus.ex_is_branch_i  = 1'b1;
        bus.ex_funct3_i     = f3;
        bus.ex_pc_i         = pc;
        bus.ex_target_i     = tgt;
        bus.ex_pred_taken_i = pred;
        op_a                = a;
        op_b                = b;
    endtask

    task automatic idle_ex();
        bus.ex_valid_i      = 1'b0;
        bus.ex_is_branch_i  = 1'b0;
        bus.ex_funct3_i     = 3'b000;
        bus.ex_pred_taken_i = 1'b0;
    endtask

    // Branch already driven and mispredicting: expect pulse, 2-cycle flush.
    task automatic expect_redirect(input string tag, input logic [31:0] pc_exp);
        tick();
        idle_ex();
        chk({tag, "_redirect"}, 32'(bus.redirect_o), 32'd1);
        chk({tag, "_redirect_pc"}, bus.redirect_pc_o, pc_exp);
        chk({tag, "_flush0"}, 32'(bus.flush_o), 32'd1);
        chk({tag, "_mispred_cnt"}, 32'(mcnt), 32'(exp_mp));
        chk({tag, "_branch_cnt"}, 32'(bcnt), 32'(exp_br));
        tick();
        chk({tag, "_redirect_end"}, 32'(bus.redirect_o), 32'd0);
        chk({tag, "_flush1"}, 32'(bus.flush_o), 32'd1);
        tick();
        chk({tag, "_flush_end"}, 32'(bus.flush_o), 32'd0);
    endtask

    // Branch already driven and predicted correctly.
    task automatic expect_quiet(input string tag);
        tick();
        idle_ex();
        chk({tag, "_no_redirect"}, 32'(bus.redirect_o), 32'd0);
        chk({tag, "_no_flush"}, 32'(bus.flush_o), 32'd0);
        chk({tag, "_branch_cnt"}, 32'(bcnt), 32'(exp_br));
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        if_pc = 32'h40;
        op_a  = '0;
        op_b  = '0;
        bus.ex_pc_i     = '0;
        bus.ex_target_i = '0;
        idle_ex();
        #2;
        chk("rst_redirect", 32'(bus.redirect_o), 32'd0);
        chk("rst_flush", 32'(bus.flush_o), 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc_o, 32'd0);
        chk("rst_branch_cnt", 32'(bcnt), 32'd0);
        chk("rst_mispred_cnt", 32'(mcnt), 32'd0);
        chk("rst_pred", 32'(if_pred), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Taken BEQ at 0x40, four times: 01 -> 10 -> 11 -> 11 -> 11.
        drive(FUNCT3_BEQ, 32'h40, 32'h80, 32'd5, 32'd5, 1'b0);
        #1;
        chk("bht_same_cycle_pre_update", 32'(if_pred), 32'd0);
        exp_br++; exp_mp++;
        expect_redirect("beq40_1", 32'h80);
        chk("bht40_after_first", 32'(if_pred), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(FUNCT3_BEQ, 32'h40, 32'h80, 32'd5, 32'd5, 1'b1);
            exp_br++;
            expect_quiet("beq40_rep");
        end
        chk("beq40_mispred_cnt", 32'(mcnt), 32'd1);
        // Saturated at 11: one not-taken leaves 10 (still predicts taken).
        drive(FUNCT3_BEQ, 32'h40, 32'h80, 32'd5, 32'd6, 1'b1);
        exp_br++; exp_mp++;
        expect_redirect("beq40_nt", 32'h44);
        chk("bht40_saturated", 32'(if_pred), 32'd1);
        drive(FUNCT3_BNE, 32'h40, 32'h80, 32'd5, 32'd5, 1'b1);
        exp_br++; exp_mp++;
        expect_redirect("bne40_nt", 32'h44);
        chk("bht40_back_to_01", 32'(if_pred), 32'd0);

        // BLT signed: -1 < 1 -> taken, mispredicted.
        drive(FUNCT3_BLT, 32'h100, 32'h200, 32'hFFFF_FFFF, 32'd1, 1'b0);
        #1;
        chk("blt_brun", 32'(bus.BrUn_o), 32'd1);
        chk("blt_brlt", 32'(bus.BrLT_i), 32'd1);
        exp_br++; exp_mp++;
        expect_redirect("blt", 32'h200);
        if_pc = 32'h100;
        #1;
        chk("bht100_taken", 32'(if_pred), 32'd1);

        // BLTU: 0xFFFFFFFF < 1 false -> not taken, predicted correctly; 01 -> 00.
        drive(FUNCT3_BLTU, 32'h104, 32'h300, 32'hFFFF_FFFF, 32'd1, 1'b0);
        #1;
        chk("bltu_brun", 32'(bus.BrUn_o), 32'd0);
        chk("bltu_brlt", 32'(bus.BrLT_i), 32'd0);
        exp_br++;
        expect_quiet("bltu");
        // BGE signed 1 >= -1 taken: 00 -> 01, so prediction stays 0.
        drive(FUNCT3_BGE, 32'h104, 32'h400, 32'd1, 32'hFFFF_FFFF, 1'b0);
        #1;
        chk("bge_brun", 32'(bus.BrUn_o), 32'd1);
        exp_br++; exp_mp++;
        expect_redirect("bge", 32'h400);
        if_pc = 32'h104;
        #1;
        chk("bht104_00_to_01", 32'(if_pred), 32'd0);

        // BEQ at the top of the address space: fall-through wraps to 0.
        drive(FUNCT3_BEQ, 32'hFFFF_FFFC, 32'h1000, 32'd7, 32'd7, 1'b0);
        exp_br++; exp_mp++;
        expect_redirect("beq_top_taken", 32'h1000);
        if_pc = 32'hFFFF_FFFC;
        #1;
        chk("bhtF_10", 32'(if_pred), 32'd1);
        drive(FUNCT3_BEQ, 32'hFFFF_FFFC, 32'h1000, 32'd7, 32'd8, 1'b1);
        exp_br++; exp_mp++;
        expect_redirect("beq_top_wrap", 32'h0);
        chk("bhtF_01", 32'(if_pred), 32'd0);

        // Mispredict followed by a 3-cycle stall.
        drive(FUNCT3_BNE, 32'h208, 32'h500, 32'd1, 32'd2, 1'b0);
        exp_br++; exp_mp++;
        tick();
        idle_ex();
        stall = 1'b1;
        #1;
        chk("stall_redirect_masked0", 32'(bus.redirect_o), 32'd0);
        chk("stall_flush0", 32'(bus.flush_o), 32'd1);
        tick();
        chk("stall_redirect_masked1", 32'(bus.redirect_o), 32'd0);
        chk("stall_flush1", 32'(bus.flush_o), 32'd1);
        tick();
        chk("stall_flush2", 32'(bus.flush_o), 32'd1);
        tick();
        stall = 1'b0;
        #1;
        chk("stall_redirect_deferred", 32'(bus.redirect_o), 32'd1);
        chk("stall_redirect_pc", bus.redirect_pc_o, 32'h500);
        chk("stall_mispred_cnt", 32'(mcnt), 32'(exp_mp));
        chk("stall_branch_cnt", 32'(bcnt), 32'(exp_br));
        tick();
        chk("stall_redirect_once", 32'(bus.redirect_o), 32'd0);
        chk("stall_flush_after", 32'(bus.flush_o), 32'd1);
        tick();
        chk("stall_flush_done", 32'(bus.flush_o), 32'd0);

        // Reset in the middle of FLUSH.
        drive(FUNCT3_BNE, 32'h20C, 32'h600, 32'd1, 32'd2, 1'b0);
        tick();
        idle_ex();
        chk("midflush_redirect", 32'(bus.redirect_o), 32'd1);
        #2;
        rst_n = 1'b0;
        if_pc = 32'h100;
        #1;
        chk("midflush_rst_redirect", 32'(bus.redirect_o), 32'd0);
        chk("midflush_rst_flush", 32'(bus.flush_o), 32'd0);
        chk("midflush_rst_pc", bus.redirect_pc_o, 32'd0);
        chk("midflush_rst_branch_cnt", 32'(bcnt), 32'd0);
        chk("midflush_rst_mispred_cnt", 32'(mcnt), 32'd0);
        chk("midflush_rst_bht", 32'(if_pred), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Illegal funct3: nothing changes even though BEQ-style compare is equal.
        drive(3'b010, 32'h100, 32'h700, 32'd3, 32'd3, 1'b0);
        #1;
        chk("illegal010_brun", 32'(bus.BrUn_o), 32'd0);
        tick();
        idle_ex();
        chk("illegal010_redirect", 32'(bus.redirect_o), 32'd0);
        chk("illegal010_flush", 32'(bus.flush_o), 32'd0);
        chk("illegal010_branch_cnt", 32'(bcnt), 32'd0);
        chk("illegal010_bht", 32'(if_pred), 32'd0);
        drive(3'b011, 32'h100, 32'h700, 32'd3, 32'd3, 1'b1);
        tick();
        idle_ex();
        chk("illegal011_redirect", 32'(bus.redirect_o), 32'd0);
        chk("illegal011_flush", 32'(bus.flush_o), 32'd0);
        chk("illegal011_mispred_cnt", 32'(mcnt), 32'd0);
        chk("illegal011_branch_cnt", 32'(bcnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
